servo_pwm_multi: RTL

//  Multi-channel servo PWM generator. One shared period counter drives CHANNELS

---
 rtl/servo_pwm_multi.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM: one shared period counter, per-channel shadow/active duty pair.
// Optional feature macro: SERVO_PWM_STAGGER_EN (spreads channel rising edges across the period).
module servo_pwm_multi #(
    parameter int CHANNELS  = 4,
    parameter int CNT_W     = 20,
    parameter int PERIOD    = 200_000,
    parameter int MIN_DC    = 10_000,
    parameter int MAX_DC    = 20_000,
    parameter int CENTER_DC = 15_000,
    parameter int STEP      = 500,
    parameter int SEL_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inc,
    input  logic                dec,
    input  logic                ld_en,
    input  logic [CNT_W-1:0]    ld_val,
    input  logic [SEL_W-1:0]    ch_sel,
    output logic [CHANNELS-1:0] pwm_out,
    output logic [CNT_W-1:0]    dc_rd,
    output logic                period_start
);

    localparam int XW = CNT_W + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] CENTER_C = CNT_W'(CENTER_DC);
    localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_DC);
    localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_DC);
    localparam logic [CNT_W-1:0] STEP_C   = CNT_W'(STEP);
    localparam logic [XW-1:0]    MIN_X    = XW'(MIN_DC);
    localparam logic [XW-1:0]    MAX_X    = XW'(MAX_DC);
    localparam logic [XW-1:0]    STEP_X   = XW'(STEP);

    logic [CNT_W-1:0] cnt;
    logic             cnt_last;

    logic [CNT_W-1:0] shadow     [CHANNELS];
    logic [CNT_W-1:0] shadow_nxt [CHANNELS];
    logic [CNT_W-1:0] active     [CHANNELS];
    logic [CNT_W-1:0] phase      [CHANNELS];
`ifdef SERVO_PWM_STAGGER_EN
    logic [CNT_W-1:0] pending    [CHANNELS];
`endif

    logic             sel_ok;
    logic             wr;
    logic [CNT_W-1:0] cur;
    logic [XW-1:0]    inc_sum;
    logic [CNT_W-1:0] inc_val;
    logic [CNT_W-1:0] dec_val;
    logic [CNT_W-1:0] ld_clamp;
    logic [CNT_W-1:0] new_val;

    assign cnt_last = (cnt == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            period_start <= 1'b0;
        end else begin
            cnt          <= cnt_last ? '0 : cnt + CNT_W'(1);
            period_start <= cnt_last;
        end
    end

    // Per-channel phase within its own period; all zero-aligned unless staggered.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
`ifdef SERVO_PWM_STAGGER_EN
            if (cnt >= CNT_W'(i * (PERIOD / CHANNELS)))
                phase[i] = cnt - CNT_W'(i * (PERIOD / CHANNELS));
            else
                phase[i] = cnt + CNT_W'(PERIOD - i * (PERIOD / CHANNELS));
`else
            phase[i] = cnt;
`endif
        end
    end

    // Command datapath: the increment is formed one bit wider so it cannot wrap.
    always_comb begin
        sel_ok = (int'(ch_sel) < CHANNELS);
        cur    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch_sel == SEL_W'(i)) cur = shadow[i];
        end

        inc_sum = {1'b0, cur} + STEP_X;
        inc_val = (inc_sum > MAX_X) ? MAX_C : inc_sum[CNT_W-1:0];
        dec_val = ({1'b0, cur} < MIN_X + STEP_X) ? MIN_C : cur - STEP_C;

        if (ld_val < MIN_C)      ld_clamp = MIN_C;
        else if (ld_val > MAX_C) ld_clamp = MAX_C;
        else                     ld_clamp = ld_val;

        if (ld_en)              new_val = ld_clamp;
        else if (inc && !dec)   new_val = inc_val;
        else if (dec && !inc)   new_val = dec_val;
        else                    new_val = cur;

        wr = sel_ok && (ld_en || (inc ^ dec));
        for (int i = 0; i < CHANNELS; i++) begin
            shadow_nxt[i] = (wr && ch_sel == SEL_W'(i)) ? new_val : shadow[i];
        end
    end

    // NOTE: the duty register arrays are reset explicitly because the reset
    // duty is architecturally visible; they are flops, not a RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadow[i]  <= CENTER_C;
                active[i]  <= CENTER_C;
`ifdef SERVO_PWM_STAGGER_EN
                pending[i] <= CENTER_C;
`endif
            end
            pwm_out <= '0;
            dc_rd   <= CENTER_C;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadow[i] <= shadow_nxt[i];
`ifdef SERVO_PWM_STAGGER_EN
                // Snapshot at the global wrap; each channel adopts it at its own phase wrap.
                if (cnt_last)
                    pending[i] <= shadow[i];
                if (phase[i] == CNT_LAST)
                    active[i] <= cnt_last ? shadow[i] : pending[i];
`else
                if (cnt_last)
                    active[i] <= shadow[i];
`endif
                pwm_out[i] <= (phase[i] < active[i]);
            end
            dc_rd <= sel_ok ? new_val : '0;
        end
    end

endmodule
